// File: rtl/regfile_pkg.sv
// Shared defaults, clear-FSM state encoding and sizing helper for the multiport register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_ADDR_W  = 6;
  localparam int unsigned DEF_NRD     = 2;
  localparam bit          DEF_ZERO_R0 = 1'b0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } clr_state_e;

  function automatic int unsigned depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/multiport_regfile_if.sv
// Write/read/clear bundle of the multiport register file; master drives requests, slave is the array.
interface multiport_regfile_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NRD    = DEF_NRD
);

  logic                    we0;
  logic                    we1;
  logic [ADDR_W-1:0]       waddr0;
  logic [ADDR_W-1:0]       waddr1;
  logic [DATA_W-1:0]       wdata0;
  logic [DATA_W-1:0]       wdata1;
  logic [NRD*ADDR_W-1:0]   raddr;
  logic [NRD*DATA_W-1:0]   rdata;
  logic                    clear;
  logic                    busy;

  modport master (
    output we0, we1, waddr0, waddr1, wdata0, wdata1, raddr, clear,
    input  rdata, busy
  );

  modport slave (
    input  we0, we1, waddr0, waddr1, wdata0, wdata1, raddr, clear,
    output rdata, busy
  );

endinterface

// File: rtl/regfile_clear_ctrl.sv
// Clear sequencer: walks every entry once, in ascending order, whenever a sweep is started.
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] sweep_addr_o
);

  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Reset lands in SWEEP so the array is zeroed after every reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      ST_SWEEP: begin
        // Counter parks on the last entry instead of wrapping.
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    busy_o       = 1'b0;
    sweep_addr_o = cnt_q;
    if (state_q == ST_SWEEP) begin
      busy_o = 1'b1;
    end
  end

endmodule

// File: rtl/multiport_regfile.sv
// Two-write, NRD-read register file with registered reads, write-first bypass and a sweeping clear.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned NRD     = DEF_NRD,
  parameter bit          ZERO_R0 = DEF_ZERO_R0
) (
  input  logic               clock,
  input  logic               reset,
  multiport_regfile_if.slave bus
);

  localparam int unsigned DEPTH = depth(ADDR_W);

  logic                  busy;
  logic [ADDR_W-1:0]     sweep_addr;
  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [NRD*DATA_W-1:0] rdata_d;
  logic [NRD*DATA_W-1:0] rdata_q;

  regfile_clear_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (bus.clear),
    .busy_o       (busy),
    .sweep_addr_o (sweep_addr)
  );

  // Storage is never reset; the sweep owns the array while busy and user writes are dropped.
  always_ff @(posedge clock) begin
    if (busy) begin
      mem_q[sweep_addr] <= '0;
    end else begin
      if (bus.we0) begin
        mem_q[bus.waddr0] <= bus.wdata0;
      end
      if (bus.we1) begin
        mem_q[bus.waddr1] <= bus.wdata1;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] lane;

    assign ra = bus.raddr[k*ADDR_W +: ADDR_W];

    // Write-first bypass; port 1 is checked last so it wins a same-address collision.
    always_comb begin
      lane = mem_q[ra];
      if (!busy) begin
        if (bus.we0 && (bus.waddr0 == ra)) begin
          lane = bus.wdata0;
        end
        if (bus.we1 && (bus.waddr1 == ra)) begin
          lane = bus.wdata1;
        end
      end
      if (ZERO_R0 && (ra == '0)) begin
        lane = '0;
      end
    end

    assign rdata_d[k*DATA_W +: DATA_W] = lane;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.busy  = busy;

endmodule

// File: tb/tb_multiport_regfile.sv
// Randomized bench for multiport_regfile: two instances (ZERO_R0 = 0 and 1) against an array model.
module tb_multiport_regfile;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 6;
  localparam int unsigned NR    = 2;
  localparam int unsigned DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  multiport_regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) bus0 ();
  multiport_regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) bus1 ();

  assign bus1.we0    = bus0.we0;
  assign bus1.we1    = bus0.we1;
  assign bus1.waddr0 = bus0.waddr0;
  assign bus1.waddr1 = bus0.waddr1;
  assign bus1.wdata0 = bus0.wdata0;
  assign bus1.wdata1 = bus0.wdata1;
  assign bus1.raddr  = bus0.raddr;
  assign bus1.clear  = bus0.clear;

  multiport_regfile #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_R0(1'b0)) u_dut0 (
    .clock (clk),
    .reset (rst),
    .bus   (bus0)
  );

  multiport_regfile #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_R0(1'b1)) u_dut1 (
    .clock (clk),
    .reset (rst),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  // Reference: contents, which entries hold a defined value, and sweep cycles still to run.
  logic [DW-1:0] mem_m   [DEPTH];
  bit            known_m [DEPTH];
  int            sweep_left;

  function automatic logic [DW-1:0] lane(input logic [NR*DW-1:0] v, input int k);
    return v[k*DW +: DW];
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    bus0.we0   = 1'b0;
    bus0.we1   = 1'b0;
    bus0.clear = 1'b0;
  endtask

  // One clock: predict from the model, advance the model, then compare after the edge.
  task automatic step();
    logic [AW-1:0] ra [NR];
    logic [DW-1:0] ev [NR];
    bit            kn [NR];
    bit            busy_now;
    int            idx;
    busy_now = (sweep_left > 0);
    for (int k = 0; k < NR; k++) begin
      ra[k] = bus0.raddr[k*AW +: AW];
      if (!busy_now && bus0.we1 && (bus0.waddr1 == ra[k])) begin
        ev[k] = bus0.wdata1;
        kn[k] = 1'b1;
      end else if (!busy_now && bus0.we0 && (bus0.waddr0 == ra[k])) begin
        ev[k] = bus0.wdata0;
        kn[k] = 1'b1;
      end else begin
        ev[k] = mem_m[ra[k]];
        kn[k] = known_m[ra[k]];
      end
    end
    if (busy_now) begin
      idx          = DEPTH - sweep_left;
      mem_m[idx]   = '0;
      known_m[idx] = 1'b1;
      sweep_left--;
    end else begin
      if (bus0.we0) begin
        mem_m[bus0.waddr0]   = bus0.wdata0;
        known_m[bus0.waddr0] = 1'b1;
      end
      if (bus0.we1) begin
        mem_m[bus0.waddr1]   = bus0.wdata1;
        known_m[bus0.waddr1] = 1'b1;
      end
      if (bus0.clear) sweep_left = DEPTH;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) begin
      if (kn[k]) check($sformatf("rd_l%0d", k), lane(bus0.rdata, k), ev[k]);
      if (kn[k] || (ra[k] == '0))
        check($sformatf("rdz_l%0d", k), lane(bus1.rdata, k), (ra[k] == '0) ? '0 : ev[k]);
    end
    check("busy0", DW'(bus0.busy), DW'(sweep_left > 0));
    check("busy1", DW'(bus1.busy), DW'(sweep_left > 0));
  endtask

  task automatic check_reset_outs();
    for (int k = 0; k < NR; k++) begin
      check($sformatf("rst_rd0_l%0d", k), lane(bus0.rdata, k), '0);
      check($sformatf("rst_rd1_l%0d", k), lane(bus1.rdata, k), '0);
    end
    check("rst_busy0", DW'(bus0.busy), DW'(1'b1));
    check("rst_busy1", DW'(bus1.busy), DW'(1'b1));
  endtask

  task automatic reset_dut(input int cycles);
    rst = 1'b1;
    #1;
    check_reset_outs();
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      check_reset_outs();
    end
    known_m[0] = 1'b0;
    sweep_left = DEPTH;
    rst        = 1'b0;
  endtask

  task automatic wait_sweep(input string tag);
    int n;
    n = 0;
    while (bus0.busy && (n < 200)) begin
      step();
      n++;
    end
    check(tag, DW'(n), DW'(DEPTH));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    set_idle();
    bus0.waddr0 = '0;
    bus0.waddr1 = '0;
    bus0.wdata0 = '0;
    bus0.wdata1 = '0;
    bus0.raddr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i]   = '0;
      known_m[i] = 1'b0;
    end
    sweep_left = 0;

    #2;
    reset_dut(2);
    wait_sweep("rst_busy_len");
    check("idle_after_rst", DW'(bus0.busy), DW'(1'b0));

    for (int i = 0; i < DEPTH; i += 2) begin
      bus0.raddr = {AW'(i + 1), AW'(i)};
      step();
      check("init_zero_l0", lane(bus0.rdata, 0), '0);
      check("init_zero_l1", lane(bus0.rdata, 1), '0);
    end

    bus0.we0 = 1'b1; bus0.waddr0 = AW'(5); bus0.wdata0 = 32'hDEADBEEF;
    step();
    set_idle();
    bus0.raddr[AW-1:0] = AW'(5);
    step();
    check("wr_rd_5", lane(bus0.rdata, 0), 32'hDEADBEEF);

    bus0.we0 = 1'b1; bus0.waddr0 = AW'(7); bus0.wdata0 = 32'h11;
    bus0.we1 = 1'b1; bus0.waddr1 = AW'(7); bus0.wdata1 = 32'h22;
    bus0.raddr[2*AW-1:AW] = AW'(7);
    step();
    check("same_addr_byp", lane(bus0.rdata, 1), 32'h22);
    set_idle();
    step();
    check("same_addr_arr", lane(bus0.rdata, 1), 32'h22);

    bus0.we0 = 1'b1; bus0.waddr0 = '0; bus0.wdata0 = 32'hFFFFFFFF;
    bus0.raddr[AW-1:0] = '0;
    step();
    check("r0_byp_z0", lane(bus0.rdata, 0), 32'hFFFFFFFF);
    check("r0_byp_z1", lane(bus1.rdata, 0), '0);
    set_idle();
    step();
    check("r0_arr_z0", lane(bus0.rdata, 0), 32'hFFFFFFFF);
    check("r0_arr_z1", lane(bus1.rdata, 0), '0);

    for (int i = 1; i <= 3; i++) begin
      bus0.we0 = 1'b1; bus0.waddr0 = AW'(i); bus0.wdata0 = 32'h100 + DW'(i);
      step();
    end
    set_idle();
    bus0.clear = 1'b1;
    step();
    bus0.clear = 1'b0;
    n = 0;
    while (bus0.busy && (n < 200)) begin
      if (n == 10) begin
        bus0.we0 = 1'b1; bus0.waddr0 = AW'(2); bus0.wdata0 = 32'hBAD0BAD0;
      end
      step();
      set_idle();
      n++;
    end
    check("clear_busy_len", DW'(n), DW'(DEPTH));
    bus0.raddr = {AW'(2), AW'(1)};
    step();
    check("clr_e1", lane(bus0.rdata, 0), '0);
    check("clr_e2", lane(bus0.rdata, 1), '0);
    bus0.raddr = {AW'(3), AW'(3)};
    step();
    check("clr_e3", lane(bus0.rdata, 0), '0);

    bus0.we0 = 1'b1; bus0.waddr0 = AW'(40); bus0.wdata0 = 32'h0000ABCD;
    step();
    set_idle();
    bus0.clear = 1'b1;
    step();
    set_idle();
    repeat (30) step();
    reset_dut(2);
    wait_sweep("rst_mid_len");
    bus0.raddr = {AW'(40), AW'(40)};
    step();
    check("rst_mid_e40", lane(bus0.rdata, 0), '0);

    repeat (800) begin
      bus0.we0    = ($urandom_range(0, 1) == 0);
      bus0.we1    = ($urandom_range(0, 2) == 0);
      bus0.waddr0 = rnd_addr();
      bus0.waddr1 = rnd_addr();
      bus0.wdata0 = $urandom;
      bus0.wdata1 = $urandom;
      bus0.raddr  = {rnd_addr(), rnd_addr()};
      bus0.clear  = ($urandom_range(0, 99) == 0);
      step();
    end
    set_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 6, address width; depth = 2**ADDR_W entries.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter ZERO_R0, default 0; when 1, entry 0 reads as zero and ignores writes.
REQ-005 SHALL have port clock, input, 1, sole clock, all state on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have ports we0, we1, input, 1 each, write enables for write ports 0 and 1.
REQ-008 SHALL have ports waddr0, waddr1, input, ADDR_W each, write addresses.
REQ-009 SHALL have ports wdata0, wdata1, input, DATA_W each, write data.
REQ-010 SHALL have port raddr, input, NRD*ADDR_W, packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-011 SHALL have port rdata, output, NRD*DATA_W, packed registered read data, same packing as raddr.
REQ-012 SHALL have port clear, input, 1, single-cycle request to zero the whole array.
REQ-013 SHALL have port busy, output, 1, high while a clear sweep is in progress.

Function
REQ-014 Reads SHALL be synchronous: rdata for port k SHALL present, one cycle after edge N, the entry at raddr[k] as sampled at edge N.
REQ-015 Writes SHALL commit at the rising edge when the enable is high and busy is low.
REQ-016 Read-during-write to the same address in the same cycle SHALL return the new data (write-first bypass).
REQ-017 When we0 and we1 target the same address in one cycle, port 1 SHALL win, both for the array and for bypass.
REQ-018 With ZERO_R0=1, reads of address 0 SHALL return 0 regardless of writes or bypass.
REQ-019 The clear FSM SHALL have states IDLE and SWEEP; IDLE->SWEEP on clear=1, SWEEP->IDLE after writing entry 2**ADDR_W-1.
REQ-020 In SWEEP, one entry per cycle SHALL be zeroed in ascending order starting at 0; the sweep takes exactly 2**ADDR_W cycles.
REQ-021 busy SHALL be high in every cycle the FSM is in SWEEP and low in IDLE.
REQ-022 While busy, we0/we1 SHALL be ignored (dropped, not queued); reads SHALL still be serviced and return current array contents.
REQ-023 clear asserted while already busy SHALL be ignored; the sweep does not restart.
REQ-024 clear and a write in the same IDLE cycle: the write SHALL commit, then the sweep SHALL zero it.
REQ-025 Address arithmetic for the sweep counter SHALL be ADDR_W bits and SHALL NOT wrap past the last entry.

Reset
REQ-026 reset SHALL asynchronously drive every rdata lane to 0.
REQ-027 reset SHALL put the FSM into SWEEP with the counter at 0, so busy=1 during reset and for 2**ADDR_W cycles after deassertion.
REQ-028 reset asserted mid-sweep SHALL restart the sweep from entry 0.
REQ-029 Array contents SHALL NOT be directly reset; zeroing comes only from the sweep.

Structure
REQ-030 The FSM state encoding and default parameter constants SHALL live in the shared package regfile_pkg.
REQ-031 The clear FSM and counter SHALL be the sub-module regfile_clear_ctrl; read ports SHALL be generated from NRD.

Verification
REQ-032 Reset then wait 64 cycles: busy=1 for 64 cycles after deassertion, then 0; every address reads 0.
REQ-033 Write 0xDEADBEEF to 5 via we0; next cycle read raddr[0]=5 -> rdata lane 0 = 0xDEADBEEF one cycle later.
REQ-034 Same cycle: we0 writes 0x11 to 7, we1 writes 0x22 to 7, raddr[1]=7 -> lane 1 = 0x22; later read of 7 = 0x22.
REQ-035 ZERO_R0=1: write 0xFFFFFFFF to 0 -> read of 0 returns 0; with ZERO_R0=0 it returns 0xFFFFFFFF.
REQ-036 Fill entries 1..3, pulse clear, attempt write to 2 at sweep cycle 10 -> busy 64 cycles, write dropped, entries 1..3 read 0.
REQ-037 Assert reset at sweep cycle 30 for 2 cycles -> rdata = 0 immediately, sweep restarts, busy for 64 cycles after release.
